// File: rtl/psr_pkg.sv
// Shared definitions for the processor status register: flag positions,
// default reset/force masks and the status word type.
package psr_pkg;

    typedef logic [7:0] psr_t;

    localparam int PSR_C = 0;
    localparam int PSR_Z = 1;
    localparam int PSR_I = 2;
    localparam int PSR_D = 3;
    localparam int PSR_B = 4;
    localparam int PSR_V = 6;
    localparam int PSR_N = 7;

    localparam psr_t PSR_RESET_VAL   = 8'h34;
    localparam psr_t PSR_FORCE1_MASK = 8'h20;

endpackage

// File: rtl/psr_lifo.sv
// Hardware LIFO of saved status words: storage, pointer, full/empty decode,
// and the push/pop/exchange decisions that the register above relies on.
module psr_lifo
    import psr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int B_BIT = PSR_B
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic             pop,
    input  logic             brk_mark,
    input  logic [WIDTH-1:0] cur_word,
    output logic [WIDTH-1:0] top_word,
    output logic             load_top,
    output logic             full,
    output logic             empty,
    output logic             ovf_evt,
    output logic             unf_evt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] save_word;
    logic [AW-1:0]    top_idx;
    logic [AW-1:0]    wr_idx;
    logic             wr_en;

    assign full    = (ptr_q == PW'(DEPTH));
    assign empty   = (ptr_q == '0);
    assign top_idx = AW'(ptr_q - 1'b1);
    assign top_word = empty ? '0 : mem_q[top_idx];

    // A pop with data available always restores, whether alone or in an exchange.
    assign load_top = pop && !empty;
    assign ovf_evt  = push && !pop && full;
    assign unf_evt  = pop && empty;

    always_comb begin
        save_word        = cur_word;
        save_word[B_BIT] = brk_mark;
    end

    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ptr_d  = ptr_q;
        wr_en  = 1'b0;
        wr_idx = AW'(ptr_q);
        if (push && pop && !empty) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push && !full) begin
            wr_en  = 1'b1;
            wr_idx = AW'(ptr_q);
            ptr_d  = ptr_q + 1'b1;
        end else if (pop && !push && !empty) begin
            ptr_d  = ptr_q - 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

    // NOTE: the storage array is deliberately not reset; an empty pointer already hides its contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_idx] <= save_word;
    end

endmodule

// File: rtl/status_register_stack.sv
// Processor status register with per-bit source priority, sticky LIFO error
// flags and a hardware stack of saved status words for interrupt entry/exit.
module status_register_stack
    import psr_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter int               DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = PSR_RESET_VAL,
    parameter logic [WIDTH-1:0] FORCE1_MASK = PSR_FORCE1_MASK,
    parameter int               B_BIT       = PSR_B
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [WIDTH-1:0] db_in,
    input  logic [WIDTH-1:0] db_en,
    input  logic [WIDTH-1:0] alu_flags,
    input  logic [WIDTH-1:0] alu_en,
    input  logic [WIDTH-1:0] man_val,
    input  logic [WIDTH-1:0] man_en,
    input  logic             push,
    input  logic             pop,
    input  logic             brk_mark,
    input  logic             db_oe,
    input  logic             err_clr,
    output logic [WIDTH-1:0] psr_rcl,
    output logic [WIDTH-1:0] psr_db,
    output logic             full,
    output logic             empty,
    output logic             ovf_err,
    output logic             unf_err
);

    logic [WIDTH-1:0] psr_q;
    logic [WIDTH-1:0] psr_d;
    logic [WIDTH-1:0] top_word;
    logic             load_top;
    logic             ovf_evt;
    logic             unf_evt;
    logic             ovf_q;
    logic             ovf_d;
    logic             unf_q;
    logic             unf_d;

    psr_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .B_BIT (B_BIT)
    ) u_lifo (
        .clk      (clk),
        .nrst     (nrst),
        .push     (push),
        .pop      (pop),
        .brk_mark (brk_mark),
        .cur_word (psr_q),
        .top_word (top_word),
        .load_top (load_top),
        .full     (full),
        .empty    (empty),
        .ovf_evt  (ovf_evt),
        .unf_evt  (unf_evt)
    );

    always_comb begin
        psr_d = psr_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (man_en[i])      psr_d[i] = man_val[i];
            else if (alu_en[i]) psr_d[i] = alu_flags[i];
            else if (db_en[i])  psr_d[i] = db_in[i];
        end
        // A restore from the stack wins over every same-cycle source load.
        if (load_top) psr_d = top_word;
        psr_d = psr_d | FORCE1_MASK;
    end

    // A fresh error in the clearing cycle keeps the flag set.
    always_comb begin
        ovf_d = ovf_evt || (ovf_q && !err_clr);
        unf_d = unf_evt || (unf_q && !err_clr);
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            psr_q <= RESET_VAL | FORCE1_MASK;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            psr_q <= psr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign psr_rcl = psr_q;
    assign psr_db  = db_oe ? psr_q : '0;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_status_register_stack.sv
// Directed self-checking bench for status_register_stack (default parameters).
module tb_status_register_stack;

    logic       clk;
    logic       nrst;
    logic [7:0] db_in, db_en, alu_flags, alu_en, man_val, man_en;
    logic       push, pop, brk_mark, db_oe, err_clr;
    logic [7:0] psr_rcl, psr_db;
    logic       full, empty, ovf_err, unf_err;

    int total;
    int bad;

    status_register_stack dut (
        .clk       (clk),
        .nrst      (nrst),
        .db_in     (db_in),
        .db_en     (db_en),
        .alu_flags (alu_flags),
        .alu_en    (alu_en),
        .man_val   (man_val),
        .man_en    (man_en),
        .push      (push),
        .pop       (pop),
        .brk_mark  (brk_mark),
        .db_oe     (db_oe),
        .err_clr   (err_clr),
        .psr_rcl   (psr_rcl),
        .psr_db    (psr_db),
        .full      (full),
        .empty     (empty),
        .ovf_err   (ovf_err),
        .unf_err   (unf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        db_in = 8'h00; db_en = 8'h00; alu_flags = 8'h00; alu_en = 8'h00;
        man_val = 8'h00; man_en = 8'h00;
        push = 1'b0; pop = 1'b0; brk_mark = 1'b0; db_oe = 1'b0; err_clr = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        nrst = 1'b0;
        #3;
        nrst = 1'b1;
        tick();
    endtask

    task automatic load_reg(input logic [7:0] v);
        man_en = 8'hFF; man_val = v;
        tick();
        man_en = 8'h00;
    endtask

    task automatic test_reset();
        do_reset();
        load_reg(8'hC3);
        push = 1'b1;
        tick();
        tick();
        total++;
        if (empty !== 1'b0) begin bad++; $display("FAIL pre_reset_empty got=%b exp=0", empty); end
        #1;
        nrst = 1'b0;
        #1;
        total++;
        if (psr_rcl !== 8'h34) begin bad++; $display("FAIL reset_psr got=%h exp=34", psr_rcl); end
        total++;
        if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_empty_full got=%b%b exp=10", empty, full); end
        total++;
        if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin bad++; $display("FAIL reset_errs got=%b%b exp=00", ovf_err, unf_err); end
        clear_inputs();
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        db_in = 8'hFF; db_en = 8'h01; alu_en = 8'h01; man_en = 8'h01;
        alu_flags = 8'h00; man_val = 8'h00;
        tick();
        total++;
        if (psr_rcl !== 8'h34) begin bad++; $display("FAIL prio_man got=%h exp=34", psr_rcl); end
        man_en = 8'h00;
        tick();
        total++;
        if (psr_rcl !== 8'h34) begin bad++; $display("FAIL prio_alu got=%h exp=34", psr_rcl); end
        alu_en = 8'h00;
        tick();
        total++;
        if (psr_rcl !== 8'h35) begin bad++; $display("FAIL prio_db got=%h exp=35", psr_rcl); end
    endtask

    task automatic test_push_pop();
        do_reset();
        load_reg(8'hE7);
        total++;
        if (psr_rcl !== 8'hE7) begin bad++; $display("FAIL pp_load got=%h exp=e7", psr_rcl); end
        push = 1'b1; brk_mark = 1'b1;
        tick();
        push = 1'b0; brk_mark = 1'b0;
        total++;
        if (empty !== 1'b0) begin bad++; $display("FAIL pp_not_empty got=%b exp=0", empty); end
        load_reg(8'h00);
        total++;
        if (psr_rcl !== 8'h20) begin bad++; $display("FAIL pp_force1 got=%h exp=20", psr_rcl); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        total++;
        if (psr_rcl !== 8'hF7) begin bad++; $display("FAIL pp_restore got=%h exp=f7", psr_rcl); end
        total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL pp_empty got=%b exp=1", empty); end
    endtask

    task automatic test_full();
        logic [7:0] exp_pop [4];
        exp_pop[0] = 8'h28; exp_pop[1] = 8'h24; exp_pop[2] = 8'h22; exp_pop[3] = 8'h21;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            load_reg(8'h01 << i);
            push = 1'b1;
            tick();
            push = 1'b0;
        end
        total++;
        if (full !== 1'b1 || ovf_err !== 1'b0) begin bad++; $display("FAIL full_set got=%b%b exp=10", full, ovf_err); end
        load_reg(8'h40);
        push = 1'b1; man_en = 8'hFF; man_val = 8'h0F;
        tick();
        push = 1'b0; man_en = 8'h00;
        total++;
        if (full !== 1'b1 || ovf_err !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b%b exp=11", full, ovf_err); end
        total++;
        if (psr_rcl !== 8'h2F) begin bad++; $display("FAIL full_load_proceeds got=%h exp=2f", psr_rcl); end
        tick();
        total++;
        if (ovf_err !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        total++;
        if (ovf_err !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", ovf_err); end
        for (int i = 0; i < 4; i++) begin
            pop = 1'b1;
            tick();
            pop = 1'b0;
            total++;
            if (psr_rcl !== exp_pop[i]) begin bad++; $display("FAIL full_pop%0d got=%h exp=%h", i, psr_rcl, exp_pop[i]); end
            total++;
            if (full !== 1'b0) begin bad++; $display("FAIL full_clear%0d got=%b exp=0", i, full); end
        end
        total++;
        if (empty !== 1'b1 || unf_err !== 1'b0) begin bad++; $display("FAIL full_drained got=%b%b exp=10", empty, unf_err); end
    endtask

    task automatic test_exchange();
        do_reset();
        load_reg(8'h01);
        push = 1'b1;
        tick();
        push = 1'b0;
        load_reg(8'h80);
        total++;
        if (psr_rcl !== 8'hA0) begin bad++; $display("FAIL xchg_pre got=%h exp=a0", psr_rcl); end
        push = 1'b1; pop = 1'b1; brk_mark = 1'b0;
        tick();
        push = 1'b0; pop = 1'b0;
        total++;
        if (psr_rcl !== 8'h21) begin bad++; $display("FAIL xchg_reg got=%h exp=21", psr_rcl); end
        total++;
        if (empty !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL xchg_ptr got=%b%b exp=00", empty, full); end
        total++;
        if (ovf_err !== 1'b0 || unf_err !== 1'b0) begin bad++; $display("FAIL xchg_errs got=%b%b exp=00", ovf_err, unf_err); end
        pop = 1'b1;
        tick();
        pop = 1'b0;
        total++;
        if (psr_rcl !== 8'hA0) begin bad++; $display("FAIL xchg_top got=%h exp=a0", psr_rcl); end
        total++;
        if (empty !== 1'b1) begin bad++; $display("FAIL xchg_empty got=%b exp=1", empty); end
    endtask

    task automatic test_underflow();
        do_reset();
        db_en = 8'hFF; db_in = 8'h5A; pop = 1'b1; db_oe = 1'b1;
        tick();
        pop = 1'b0; db_en = 8'h00;
        total++;
        if (psr_rcl !== 8'h7A) begin bad++; $display("FAIL unf_reg got=%h exp=7a", psr_rcl); end
        total++;
        if (unf_err !== 1'b1) begin bad++; $display("FAIL unf_set got=%b exp=1", unf_err); end
        total++;
        if (psr_db !== 8'h7A) begin bad++; $display("FAIL db_oe_on got=%h exp=7a", psr_db); end
        db_oe = 1'b0;
        #1;
        total++;
        if (psr_db !== 8'h00) begin bad++; $display("FAIL db_oe_off got=%h exp=00", psr_db); end
        pop = 1'b1; err_clr = 1'b1;
        tick();
        pop = 1'b0;
        total++;
        if (unf_err !== 1'b1) begin bad++; $display("FAIL unf_clr_race got=%b exp=1", unf_err); end
        tick();
        err_clr = 1'b0;
        total++;
        if (unf_err !== 1'b0) begin bad++; $display("FAIL unf_clr got=%b exp=0", unf_err); end
        push = 1'b1; pop = 1'b1;
        tick();
        push = 1'b0; pop = 1'b0;
        total++;
        if (empty !== 1'b0 || unf_err !== 1'b1) begin bad++; $display("FAIL pushpop_empty got=%b%b exp=01", empty, unf_err); end
        total++;
        if (psr_rcl !== 8'h7A) begin bad++; $display("FAIL pushpop_empty_reg got=%h exp=7a", psr_rcl); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear_inputs();
        nrst = 1'b0;
        #12;
        nrst = 1'b1;
        test_reset();
        test_priority();
        test_push_pop();
        test_full();
        test_exchange();
        test_underflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
